// File: rtl/psum_pkg.sv
// Shared types and SRAM control encodings for the partial-sum read-modify-write controller.
package psum_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAccRd,
      StAccWr,
      StOutRd,
      StOutCap
   } psum_state_e;

   localparam logic CEN_ON      = 1'b0;
   localparam logic CEN_OFF     = 1'b1;
   localparam logic RDWEN_WRITE = 1'b0;
   localparam logic RDWEN_READ  = 1'b1;

endpackage

// File: rtl/psum_sat_add.sv
// Combinational signed add of two psum words with optional saturation to the word range.
module psum_sat_add #(
   parameter int unsigned W        = 32,
   parameter bit          SATURATE = 1'b1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         clip
);

   logic [W:0] ext;
   logic       ovf;

   // One guard bit: overflow shows up as the top two bits disagreeing.
   assign ext = {a[W-1], a} + {b[W-1], b};
   assign ovf = ext[W] ^ ext[W-1];

   always_comb begin
      sum  = ext[W-1:0];
      clip = 1'b0;
      if (SATURATE && ovf) begin
         clip = 1'b1;
         sum  = ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/psum_rmw_ctrl.sv
// Single-bank psum controller: accumulate (read-modify-write or overwrite) and readout requests
// serialised onto one SRAM port with active-low CEN/RDWEN and 1-cycle read latency.
module psum_rmw_ctrl #(
   parameter int unsigned ADR_W    = 12,
   parameter int unsigned SRAM_W   = 32,
   parameter bit          SATURATE = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_acc_valid,
   output logic              o_acc_ready,
   input  logic [ADR_W-1:0]  i_acc_addr,
   input  logic [SRAM_W-1:0] i_acc_data,
   input  logic              i_acc_first,
   input  logic              i_rd_valid,
   output logic              o_rd_ready,
   input  logic [ADR_W-1:0]  i_rd_addr,
   output logic              o_rd_data_valid,
   output logic [SRAM_W-1:0] o_rd_data,
   input  logic              i_sat_clr,
   output logic              o_sat_flag,
   output logic              o_busy,
   output logic              o_sram_cen,
   output logic              o_sram_rdwen,
   output logic [ADR_W-1:0]  o_sram_addr,
   output logic [SRAM_W-1:0] o_sram_wdata,
   output logic [SRAM_W-1:0] o_sram_wmask,
   input  logic [SRAM_W-1:0] i_sram_rdata
);

   import psum_pkg::*;

   psum_state_e       state_q;
   logic [SRAM_W-1:0] data_q;
   logic              first_q;
   logic [SRAM_W-1:0] wdata_q;
   logic [SRAM_W-1:0] sum;
   logic              clip;
   logic [SRAM_W-1:0] wr_word;
   logic              sat_set;

   psum_sat_add #(
      .W        (SRAM_W),
      .SATURATE (SATURATE)
   ) u_sat_add (
      .a    (i_sram_rdata),
      .b    (data_q),
      .sum  (sum),
      .clip (clip)
   );

   assign o_acc_ready = (state_q == StIdle);
   assign o_rd_ready  = (state_q == StIdle) & ~i_acc_valid;
   assign o_busy      = (state_q != StIdle);

   // Read data only arrives during the write cycle, so the write word is formed combinationally
   // there and latched in wdata_q so the bus holds it afterwards.
   assign wr_word      = first_q ? data_q : sum;
   assign o_sram_wdata = (state_q == StAccWr) ? wr_word : wdata_q;
   assign sat_set      = (state_q == StAccWr) & ~first_q & clip;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q         <= StIdle;
         data_q          <= '0;
         first_q         <= 1'b0;
         wdata_q         <= '0;
         o_sram_cen      <= CEN_OFF;
         o_sram_rdwen    <= RDWEN_READ;
         o_sram_addr     <= '0;
         o_sram_wmask    <= '0;
         o_rd_data       <= '0;
         o_rd_data_valid <= 1'b0;
         o_sat_flag      <= 1'b0;
      end else begin
         o_rd_data_valid <= 1'b0;
         if (sat_set) begin
            o_sat_flag <= 1'b1;
         end else if (i_sat_clr) begin
            o_sat_flag <= 1'b0;
         end
         unique case (state_q)
            StIdle: begin
               if (i_acc_valid) begin
                  data_q      <= i_acc_data;
                  first_q     <= i_acc_first;
                  o_sram_addr <= i_acc_addr;
                  o_sram_cen  <= CEN_ON;
                  if (i_acc_first) begin
                     o_sram_rdwen <= RDWEN_WRITE;
                     o_sram_wmask <= '1;
                     state_q      <= StAccWr;
                  end else begin
                     o_sram_rdwen <= RDWEN_READ;
                     state_q      <= StAccRd;
                  end
               end else if (i_rd_valid) begin
                  o_sram_addr  <= i_rd_addr;
                  o_sram_cen   <= CEN_ON;
                  o_sram_rdwen <= RDWEN_READ;
                  state_q      <= StOutRd;
               end
            end
            StAccRd: begin
               o_sram_rdwen <= RDWEN_WRITE;
               o_sram_wmask <= '1;
               state_q      <= StAccWr;
            end
            StAccWr: begin
               wdata_q      <= wr_word;
               o_sram_cen   <= CEN_OFF;
               o_sram_rdwen <= RDWEN_READ;
               o_sram_wmask <= '0;
               state_q      <= StIdle;
            end
            StOutRd: begin
               o_sram_cen <= CEN_OFF;
               state_q    <= StOutCap;
            end
            StOutCap: begin
               o_rd_data       <= i_sram_rdata;
               o_rd_data_valid <= 1'b1;
               state_q         <= StIdle;
            end
            default: begin
               o_sram_cen   <= CEN_OFF;
               o_sram_rdwen <= RDWEN_READ;
               o_sram_wmask <= '0;
               state_q      <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psum_rmw_ctrl.sv
// Directed bench for psum_rmw_ctrl: behavioural SRAM, per-cycle expected bus schedule built from
// a reference memory, plus literal expectations for the documented scenarios.
module tb_psum_rmw_ctrl;

   localparam int ADR_W = 12;
   localparam int SRAM_W = 32;
   localparam int DEPTH = 4096;
   localparam int NCYC = 4096;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic              i_clk;
   logic              i_rstn;
   logic              i_acc_valid;
   logic              o_acc_ready;
   logic [ADR_W-1:0]  i_acc_addr;
   logic [SRAM_W-1:0] i_acc_data;
   logic              i_acc_first;
   logic              i_rd_valid;
   logic              o_rd_ready;
   logic [ADR_W-1:0]  i_rd_addr;
   logic              o_rd_data_valid;
   logic [SRAM_W-1:0] o_rd_data;
   logic              i_sat_clr;
   logic              o_sat_flag;
   logic              o_busy;
   logic              o_sram_cen;
   logic              o_sram_rdwen;
   logic [ADR_W-1:0]  o_sram_addr;
   logic [SRAM_W-1:0] o_sram_wdata;
   logic [SRAM_W-1:0] o_sram_wmask;
   logic [SRAM_W-1:0] i_sram_rdata;

   psum_rmw_ctrl #(
      .ADR_W    (ADR_W),
      .SRAM_W   (SRAM_W),
      .SATURATE (1'b1)
   ) dut (
      .i_clk           (i_clk),
      .i_rstn          (i_rstn),
      .i_acc_valid     (i_acc_valid),
      .o_acc_ready     (o_acc_ready),
      .i_acc_addr      (i_acc_addr),
      .i_acc_data      (i_acc_data),
      .i_acc_first     (i_acc_first),
      .i_rd_valid      (i_rd_valid),
      .o_rd_ready      (o_rd_ready),
      .i_rd_addr       (i_rd_addr),
      .o_rd_data_valid (o_rd_data_valid),
      .o_rd_data       (o_rd_data),
      .i_sat_clr       (i_sat_clr),
      .o_sat_flag      (o_sat_flag),
      .o_busy          (o_busy),
      .o_sram_cen      (o_sram_cen),
      .o_sram_rdwen    (o_sram_rdwen),
      .o_sram_addr     (o_sram_addr),
      .o_sram_wdata    (o_sram_wdata),
      .o_sram_wmask    (o_sram_wmask),
      .i_sram_rdata    (i_sram_rdata)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Expected per-cycle behaviour: kind 0 idle bus, 1 read, 2 write.
   int          s_kind[NCYC];
   logic [31:0] s_addr[NCYC];
   logic [31:0] s_wdata[NCYC];
   bit          s_busy[NCYC];
   bit          s_rdv[NCYC];
   logic [31:0] s_rdd[NCYC];
   bit          s_flag_set[NCYC];
   logic [31:0] ref_mem[DEPTH];
   bit          flag_m = 1'b0;

   logic [31:0] mem[DEPTH];
   logic [31:0] sram_q = 32'h0;
   int          n_rd = 0;
   int          n_wr = 0;
   logic [31:0] last_wdata = 32'h0;
   logic [31:0] last_wmask = 32'h0;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Bank model: registered read data, garbage on outdata after a write.
   always @(posedge i_clk) begin
      if (!o_sram_cen) begin
         if (!o_sram_rdwen) begin
            mem[o_sram_addr] <= (o_sram_wdata & o_sram_wmask) | (mem[o_sram_addr] & ~o_sram_wmask);
            sram_q     <= 32'hDEADBEEF;
            n_wr       <= n_wr + 1;
            last_wdata <= o_sram_wdata;
            last_wmask <= o_sram_wmask;
         end else begin
            sram_q <= mem[o_sram_addr];
            n_rd   <= n_rd + 1;
         end
      end
   end
   assign i_sram_rdata = sram_q;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   always @(posedge i_clk) begin
      cyc <= cyc + 1;
      if (!i_rstn) flag_m <= 1'b0;
      else if (s_flag_set[cyc+1]) flag_m <= 1'b1;
      else if (i_sat_clr) flag_m <= 1'b0;
   end

   always @(negedge i_clk) begin
      if (i_rstn) begin
         chk("cen", {31'b0, o_sram_cen}, {31'b0, s_kind[cyc] == 0});
         chk("busy", {31'b0, o_busy}, {31'b0, s_busy[cyc]});
         chk("acc_ready", {31'b0, o_acc_ready}, {31'b0, !s_busy[cyc]});
         chk("rd_valid", {31'b0, o_rd_data_valid}, {31'b0, s_rdv[cyc]});
         chk("sat_flag", {31'b0, o_sat_flag}, {31'b0, flag_m});
         if (s_kind[cyc] != 0) begin
            chk("addr", {20'b0, o_sram_addr}, s_addr[cyc]);
            chk("rdwen", {31'b0, o_sram_rdwen}, {31'b0, s_kind[cyc] == 1});
            chk("wmask", o_sram_wmask, (s_kind[cyc] == 2) ? 32'hFFFFFFFF : 32'h0);
            if (s_kind[cyc] == 2) chk("wdata", o_sram_wdata, s_wdata[cyc]);
         end else begin
            chk("wmask_idle", o_sram_wmask, 32'h0);
         end
         if (s_rdv[cyc]) chk("rd_data", o_rd_data, s_rdd[cyc]);
      end else begin
         chk("rst_cen", {31'b0, o_sram_cen}, 32'h1);
         chk("rst_rdwen", {31'b0, o_sram_rdwen}, 32'h1);
         chk("rst_addr", {20'b0, o_sram_addr}, 32'h0);
         chk("rst_wdata", o_sram_wdata, 32'h0);
         chk("rst_wmask", o_sram_wmask, 32'h0);
         chk("rst_rd_data", o_rd_data, 32'h0);
         chk("rst_rd_valid", {31'b0, o_rd_data_valid}, 32'h0);
         chk("rst_sat_flag", {31'b0, o_sat_flag}, 32'h0);
         chk("rst_busy", {31'b0, o_busy}, 32'h0);
      end
   end

   // Returns c = number of the posedge that accepts the request, after that edge.
   task automatic wait_ready(input bit is_acc, output int c);
      c = -1;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (is_acc ? o_acc_ready : o_rd_ready) begin
            c = cyc + 1;
            @(posedge i_clk);
            return;
         end
         @(negedge i_clk);
      end
      checks++;
      errors++;
      $display("FAIL accept_timeout is_acc=%0d actual=no_ready required=ready", is_acc);
   endtask

   task automatic do_acc(input logic [11:0] a, input logic [31:0] d, input bit f, output int c);
      longint s;
      logic [31:0] nv;
      bit clipped;
      clipped = 1'b0;
      i_acc_valid = 1'b1;
      i_acc_addr  = a;
      i_acc_data  = d;
      i_acc_first = f;
      wait_ready(1'b1, c);
      if (c >= 0) begin
         if (f) begin
            nv = d;
         end else begin
            s = longint'($signed(ref_mem[a])) + longint'($signed(d));
            if (s > SMAX) begin
               s = SMAX;
               clipped = 1'b1;
            end else if (s < SMIN) begin
               s = SMIN;
               clipped = 1'b1;
            end
            nv = s[31:0];
         end
         ref_mem[a] = nv;
         if (f) begin
            s_kind[c] = 2; s_addr[c] = {20'b0, a}; s_wdata[c] = nv; s_busy[c] = 1'b1;
         end else begin
            s_kind[c] = 1; s_addr[c] = {20'b0, a}; s_busy[c] = 1'b1;
            s_kind[c+1] = 2; s_addr[c+1] = {20'b0, a}; s_wdata[c+1] = nv; s_busy[c+1] = 1'b1;
            s_flag_set[c+2] = clipped;
         end
      end
      @(negedge i_clk);
      i_acc_valid = 1'b0;
   endtask

   // lat is counted to the first cycle the pulse is visible; the next edge samples it.
   task automatic do_rd(input logic [11:0] a, output logic [31:0] got, output int lat,
                        output int c);
      got = 32'hX;
      lat = -1;
      i_rd_valid = 1'b1;
      i_rd_addr  = a;
      wait_ready(1'b0, c);
      if (c >= 0) begin
         s_kind[c] = 1; s_addr[c] = {20'b0, a}; s_busy[c] = 1'b1; s_busy[c+1] = 1'b1;
         s_rdv[c+2] = 1'b1; s_rdd[c+2] = ref_mem[a];
      end
      @(negedge i_clk);
      i_rd_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (o_rd_data_valid) begin
            got = o_rd_data;
            lat = cyc - c;
            return;
         end
         @(negedge i_clk);
      end
      checks++;
      errors++;
      $display("FAIL rd_valid_timeout actual=no_pulse required=pulse addr=%h", a);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, c2, lat, nr, nw;
      logic [31:0] got;
      i_rstn = 1'b0; i_acc_valid = 1'b0; i_acc_addr = '0; i_acc_data = '0; i_acc_first = 1'b0;
      i_rd_valid = 1'b0; i_rd_addr = '0; i_sat_clr = 1'b0;
      repeat (3) @(negedge i_clk);
      #2 i_rstn = 1'b1;
      @(negedge i_clk);

      // 1: overwrite then accumulate, read back.
      do_acc(12'd5, 32'd100, 1'b1, c);
      do_acc(12'd5, 32'd23, 1'b0, c);
      do_rd(12'd5, got, lat, c);
      chk("t1_rd_data", got, 32'd123);
      chk("t1_model", ref_mem[5], 32'd123);
      chk("t1_latency", lat, 32'd2);

      // 2: one read and one write for a non-first accumulate.
      do_acc(12'd7, -32'sd50, 1'b1, c);
      idle(2);
      nr = n_rd; nw = n_wr;
      do_acc(12'd7, 32'd20, 1'b0, c);
      idle(3);
      chk("t2_reads", n_rd - nr, 32'd1);
      chk("t2_writes", n_wr - nw, 32'd1);
      chk("t2_wdata", last_wdata, 32'hFFFFFFE2);
      chk("t2_wmask", last_wmask, 32'hFFFFFFFF);

      // 3: positive saturation and sticky flag clear.
      do_acc(12'd3, 32'h7FFFFFF0, 1'b1, c);
      do_acc(12'd3, 32'h00000020, 1'b0, c);
      idle(3);
      chk("t3_wdata", last_wdata, 32'h7FFFFFFF);
      chk("t3_flag_set", {31'b0, o_sat_flag}, 32'h1);
      i_sat_clr = 1'b1;
      @(negedge i_clk);
      i_sat_clr = 1'b0;
      #1 chk("t3_flag_clr", {31'b0, o_sat_flag}, 32'h0);
      @(negedge i_clk);

      // 4: accumulate wins over simultaneous readout.
      i_acc_valid = 1'b1; i_acc_addr = 12'd5; i_acc_data = 32'd10; i_acc_first = 1'b0;
      i_rd_valid = 1'b1; i_rd_addr = 12'd7;
      #1;
      chk("t4_acc_ready", {31'b0, o_acc_ready}, 32'h1);
      chk("t4_rd_ready", {31'b0, o_rd_ready}, 32'h0);
      do_acc(12'd5, 32'd10, 1'b0, c);
      do_rd(12'd7, got, lat, c2);
      chk("t4_rd_accept_gap", c2 - c, 32'd3);
      chk("t4_rd_data", got, 32'hFFFFFFE2);

      // 5: back-to-back accumulates at the top address.
      do_acc(12'hFFF, 32'd0, 1'b1, c);
      for (int i = 0; i < 4; i++) do_acc(12'hFFF, 32'd1, 1'b0, c);
      do_rd(12'hFFF, got, lat, c);
      chk("t5_rd_data", got, 32'd4);

      // 6: reset during ACC_RD drops the write.
      do_acc(12'd9, 32'd77, 1'b1, c);
      idle(2);
      nw = n_wr;
      i_acc_valid = 1'b1; i_acc_addr = 12'd9; i_acc_data = 32'd5; i_acc_first = 1'b0;
      wait_ready(1'b1, c);
      if (c >= 0) begin
         s_kind[c] = 1; s_addr[c] = 32'd9; s_busy[c] = 1'b1;
      end
      @(negedge i_clk);
      i_acc_valid = 1'b0;
      #2 i_rstn = 1'b0;
      #1;
      chk("t6_cen_async", {31'b0, o_sram_cen}, 32'h1);
      chk("t6_busy_async", {31'b0, o_busy}, 32'h0);
      repeat (2) @(negedge i_clk);
      #2 i_rstn = 1'b1;
      idle(2);
      chk("t6_no_write", n_wr - nw, 32'd0);
      do_rd(12'd9, got, lat, c);
      chk("t6_rd_data", got, 32'd77);

      idle(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
